// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO deserializer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package sipo_pkg;

    // Framing state: HUNT waits for a frame_start, SHIFT is collecting a word.
    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } sipo_state_t;

    // Width of the bit counter. It only ever holds 0..WIDTH-1.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input and parallel valid/ready output bundle of the deserializer.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer stalls the one-entry output buffer.
interface sipo_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             serial_in;
    logic             bit_valid;
    logic             frame_start;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_ready;
    logic             overflow;
    logic             frame_err;

    // Deserializer side: takes serial bits and the consumer's ready, drives the word and flags.
    modport master (
        input  serial_in,
        input  bit_valid,
        input  frame_start,
        input  out_ready,
        output parallel_out,
        output out_valid,
        output overflow,
        output frame_err
    );

    // Environment side: serial source plus parallel consumer.
    modport slave (
        output serial_in,
        output bit_valid,
        output frame_start,
        output out_ready,
        input  parallel_out,
        input  out_valid,
        input  overflow,
        input  frame_err
    );
endinterface

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready output register for assembled words.
// Latency: a load at edge N is visible on parallel_out_o/out_valid_o after edge N.
// Backpressure: can_load_o is low while a word is held and out_ready_i is low; loads are then refused.
module sipo_out_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] parallel_out_o,
    output logic             out_valid_o,
    output logic             can_load_o
);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    // A slot is free when empty or when the held word is being taken this cycle.
    assign can_load_o = !valid_q || out_ready_i;

    // Hold the word until consumed; a refused load leaves the held word untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i && can_load_o) begin
            data_q  <= load_data_i;
            valid_q <= 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign parallel_out_o = data_q;
    assign out_valid_o    = valid_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Framed serial-in/parallel-out deserializer with a one-entry valid/ready output buffer.
// Latency: word valid on the cycle after its last bit is accepted; one bit per cycle when bit_valid is held high.
// Backpressure: a word completing while the buffer is full and not draining is dropped and flagged by overflow.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    sipo_deserializer_if.master  bus
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    sipo_state_t      state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;
    logic             overflow_q;
    logic             frame_err_q;

    logic [WIDTH-1:0] shifted_word;
    logic [WIDTH-1:0] first_word;
    logic             load_req;
    logic             can_load;

    // Candidate register contents for a continuing bit and for a new bit 0, plus word completion.
    always_comb begin
        shifted_word = '0;
        first_word   = '0;
        if (MSB_FIRST) begin
            shifted_word = {shreg_q[WIDTH-2:0], bus.serial_in};
            first_word   = {{(WIDTH-1){1'b0}}, bus.serial_in};
        end else begin
            shifted_word = {bus.serial_in, shreg_q[WIDTH-1:1]};
            first_word   = {bus.serial_in, {(WIDTH-1){1'b0}}};
        end
        // A frame_start bit always begins a new word, so it can never be the last bit.
        load_req = bus.bit_valid && !bus.frame_start &&
                   (state_q == SHIFT) && (cnt_q == CNT_LAST);
    end

    // Framing FSM, shift register, bit counter and the registered status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            shreg_q     <= '0;
            cnt_q       <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            overflow_q  <= load_req && !can_load;
            frame_err_q <= 1'b0;
            if (bus.bit_valid) begin
                if (bus.frame_start) begin
                    // Mid-word frame_start drops the partial word and resyncs on this bit.
                    frame_err_q <= (state_q == SHIFT);
                    shreg_q     <= first_word;
                    cnt_q       <= CNT_ONE;
                    state_q     <= SHIFT;
                end else if (state_q == SHIFT) begin
                    shreg_q <= shifted_word;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= HUNT;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
            end
        end
    end

    sipo_out_buf #(
        .WIDTH (WIDTH)
    ) u_out_buf (
        .clk            (clk),
        .rst            (rst),
        .load_i         (load_req),
        .load_data_i    (shifted_word),
        .out_ready_i    (bus.out_ready),
        .parallel_out_o (bus.parallel_out),
        .out_valid_o    (bus.out_valid),
        .can_load_o     (can_load)
    );

    assign bus.overflow  = overflow_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one MSB-first and one LSB-first instance fed the same stream.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: out_ready driven directly by the stimulus.
module tb_sipo_deserializer;

    logic clk;
    logic rst;
    logic serial_in;
    logic bit_valid;
    logic frame_start;
    logic out_ready;

    int n_checks;
    int n_errors;

    sipo_deserializer_if #(.WIDTH(8)) bus_m ();
    sipo_deserializer_if #(.WIDTH(8)) bus_l ();

    assign bus_m.serial_in   = serial_in;
    assign bus_m.bit_valid   = bit_valid;
    assign bus_m.frame_start = frame_start;
    assign bus_m.out_ready   = out_ready;
    assign bus_l.serial_in   = serial_in;
    assign bus_l.bit_valid   = bit_valid;
    assign bus_l.frame_start = frame_start;
    assign bus_l.out_ready   = out_ready;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        serial_in   = b;
        bit_valid   = 1'b1;
        frame_start = fs;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    // seq[7] goes out first; optional idle cycles between bits; optionally raise out_ready with the last bit.
    task automatic send_word(input logic [7:0] seq, input int gap, input bit ready_on_last);
        for (int i = 0; i < 8; i++) begin
            if (i == 7 && ready_on_last) out_ready = 1'b1;
            send_bit(seq[7-i], i == 0);
            if (i < 7) repeat (gap) tick();
        end
    endtask

    initial begin
        logic [7:0] seq;
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        serial_in   = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        tick();
        rst = 1'b0;
        chk("rst_parallel_out", 32'(bus_m.parallel_out), 32'h0);
        chk("rst_out_valid",    32'(bus_m.out_valid),    32'h0);
        chk("rst_overflow",     32'(bus_m.overflow),     32'h0);
        chk("rst_frame_err",    32'(bus_m.frame_err),    32'h0);

        // Bits without frame_start are ignored in HUNT
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        tick();
        chk("hunt_no_word", 32'(bus_m.out_valid), 32'h0);

        // Basic word 1,0,1,0,0,1,0,1
        out_ready = 1'b1;
        send_word(8'hA5, 0, 1'b0);
        chk("basic_valid",   32'(bus_m.out_valid),    32'h1);
        chk("basic_word",    32'(bus_m.parallel_out), 32'hA5);
        chk("lsb_a5_word",   32'(bus_l.parallel_out), 32'hA5);
        tick();
        chk("basic_one_cycle", 32'(bus_m.out_valid), 32'h0);

        // Bit order: 1,1,0,0,0,0,0,0
        send_word(8'hC0, 0, 1'b0);
        chk("msb_c0_word", 32'(bus_m.parallel_out), 32'hC0);
        chk("lsb_03_word", 32'(bus_l.parallel_out), 32'h03);
        chk("lsb_03_valid", 32'(bus_l.out_valid),   32'h1);
        tick();

        // Gaps and backpressure
        out_ready = 1'b0;
        send_word(8'h3C, 2, 1'b0);
        chk("gap_valid", 32'(bus_m.out_valid),    32'h1);
        chk("gap_word",  32'(bus_m.parallel_out), 32'h3C);
        repeat (3) tick();
        chk("hold_valid", 32'(bus_m.out_valid),    32'h1);
        chk("hold_word",  32'(bus_m.parallel_out), 32'h3C);
        send_word(8'hC3, 0, 1'b0);
        chk("ovf_pulse",     32'(bus_m.overflow),     32'h1);
        chk("ovf_keep_word", 32'(bus_m.parallel_out), 32'h3C);
        tick();
        chk("ovf_one_cycle", 32'(bus_m.overflow), 32'h0);
        send_word(8'h0F, 0, 1'b1);
        chk("drain_load_word",  32'(bus_m.parallel_out), 32'h0F);
        chk("drain_load_valid", 32'(bus_m.out_valid),    32'h1);
        chk("drain_no_ovf",     32'(bus_m.overflow),     32'h0);
        tick();
        chk("drain_empty", 32'(bus_m.out_valid), 32'h0);

        // Resync: frame_start on the 5th bit; new word 1,0,1,1,0,0,1,0
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        seq = 8'hB2;
        send_bit(seq[7], 1'b1);
        chk("resync_err_pulse", 32'(bus_m.frame_err), 32'h1);
        for (int i = 1; i < 8; i++) begin
            send_bit(seq[7-i], 1'b0);
            if (i == 1) chk("resync_err_one_cycle", 32'(bus_m.frame_err), 32'h0);
        end
        chk("resync_word",     32'(bus_m.parallel_out), 32'hB2);
        chk("resync_valid",    32'(bus_m.out_valid),    32'h1);
        chk("resync_lsb_word", 32'(bus_l.parallel_out), 32'h4D);
        tick();

        // Reset with a buffered word and a partial word in flight
        out_ready = 1'b0;
        send_word(8'h5A, 0, 1'b0);
        chk("pre_rst_word", 32'(bus_m.parallel_out), 32'h5A);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("pre_rst_valid", 32'(bus_m.out_valid), 32'h1);
        rst         = 1'b1;
        serial_in   = 1'b1;
        bit_valid   = 1'b1;
        frame_start = 1'b1;
        tick();
        rst         = 1'b0;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        chk("mid_rst_valid",     32'(bus_m.out_valid),    32'h0);
        chk("mid_rst_word",      32'(bus_m.parallel_out), 32'h0);
        chk("mid_rst_overflow",  32'(bus_m.overflow),     32'h0);
        chk("mid_rst_frame_err", 32'(bus_m.frame_err),    32'h0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        chk("post_rst_hunt", 32'(bus_m.out_valid), 32'h0);
        seq = 8'h96;
        send_bit(seq[7], 1'b1);
        chk("post_rst_no_err", 32'(bus_m.frame_err), 32'h0);
        for (int i = 1; i < 8; i++) send_bit(seq[7-i], 1'b0);
        chk("post_rst_word",     32'(bus_m.parallel_out), 32'h96);
        chk("post_rst_valid",    32'(bus_m.out_valid),    32'h1);
        chk("post_rst_lsb_word", 32'(bus_l.parallel_out), 32'h69);
        chk("post_rst_overflow", 32'(bus_m.overflow),     32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
